// File: rtl/gcd_arbiter.sv
// Round-robin arbiter sharing one gcd unit among NREQ requesters, one transaction in flight.
// Optional watchdog enabled by defining GCD_ARB_TIMEOUT_EN.
module gcd_arbiter #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [NREQ-1:0]      req_val,
    output logic [NREQ-1:0]      req_rdy,
    input  logic [32*NREQ-1:0]   req_msg,
    output logic [NREQ-1:0]      resp_val,
    input  logic [NREQ-1:0]      resp_rdy,
    output logic [15:0]          resp_msg,
    output logic                 gcd_req_val,
    input  logic                 gcd_req_rdy,
    output logic [31:0]          gcd_req_msg,
    input  logic                 gcd_resp_val,
    output logic                 gcd_resp_rdy,
    input  logic [15:0]          gcd_resp_msg,
    output logic [1:0]           grant_id,
    output logic                 busy,
    output logic                 timeout
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RETURN} state_t;

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
    } gcd_op_t;

    if (NREQ != 4 || TIMEOUT < 2) begin : g_cfg_check
        $error("gcd_arbiter: NREQ must be 4 and TIMEOUT at least 2");
    end

    state_t      state, state_nxt;
    logic [1:0]  rr_ptr;
    gcd_op_t     op_q;
    logic [15:0] res_q;

    logic [1:0]  win;
    logic        found;
    logic        req_fire;
    logic        gcd_req_fire;
    logic        gcd_resp_fire;
    logic        ret_fire;
    logic        wd_fire;

    // First valid requester at or after rr_ptr, wrapping through the 2-bit index.
    always_comb begin
        logic [1:0] idx;
        win   = rr_ptr;
        found = 1'b0;
        idx   = rr_ptr;
        for (int k = 0; k < NREQ; k++) begin
            idx = rr_ptr + k[1:0];
            if (!found && req_val[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        req_rdy       = '0;
        resp_val      = '0;
        gcd_req_val   = 1'b0;
        gcd_resp_rdy  = 1'b0;
        req_fire      = 1'b0;
        gcd_req_fire  = 1'b0;
        gcd_resp_fire = 1'b0;
        ret_fire      = 1'b0;
        case (state)
            IDLE: begin
                // Drain any response left over from an aborted transaction.
                gcd_resp_rdy = 1'b1;
                req_rdy[win] = found;
                if (found) begin
                    req_fire  = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                gcd_req_val = 1'b1;
                if (gcd_req_rdy) begin
                    gcd_req_fire = 1'b1;
                    state_nxt    = WAIT;
                end else if (wd_fire) begin
                    state_nxt = RETURN;
                end
            end
            WAIT: begin
                gcd_resp_rdy = 1'b1;
                if (gcd_resp_val) begin
                    gcd_resp_fire = 1'b1;
                    state_nxt     = RETURN;
                end else if (wd_fire) begin
                    state_nxt = RETURN;
                end
            end
            RETURN: begin
                resp_val[grant_id] = 1'b1;
                if (resp_rdy[grant_id]) begin
                    ret_fire  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr   <= 2'd0;
            grant_id <= 2'd0;
            op_q     <= '0;
            res_q    <= 16'd0;
        end else begin
            if (req_fire) begin
                grant_id <= win;
                op_q     <= req_msg[{win, 5'd0} +: 32];
            end
            if (gcd_resp_fire)
                res_q <= gcd_resp_msg;
            else if (wd_fire)
                res_q <= 16'hFFFF;
            if (ret_fire)
                rr_ptr <= grant_id + 2'd1;
        end
    end

`ifdef GCD_ARB_TIMEOUT_EN
    localparam int WDW = $clog2(TIMEOUT) + 1;
    logic [WDW-1:0] wd_q;

    // >= rather than == so a request accepted exactly at the limit still times out in WAIT.
    assign wd_fire = ((state == ISSUE && !gcd_req_rdy) || (state == WAIT && !gcd_resp_val))
                     && (wd_q >= WDW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wd_q    <= '0;
            timeout <= 1'b0;
        end else begin
            timeout <= wd_fire;
            if (req_fire)
                wd_q <= '0;
            else if (state == ISSUE || state == WAIT)
                wd_q <= wd_q + 1'b1;
        end
    end
`else
    assign wd_fire = 1'b0;
    assign timeout = 1'b0;
`endif

    assign gcd_req_msg = op_q;
    assign resp_msg    = res_q;
    assign busy        = (state != IDLE);

endmodule

// File: tb/tb_gcd_arbiter.sv
// Directed bench for gcd_arbiter: reset, single request, round robin, backpressure,
// reset mid-transaction and watchdog behaviour (GCD_ARB_TIMEOUT_EN selects the variant).
module tb_gcd_arbiter;

`ifdef GCD_ARB_TIMEOUT_EN
    localparam int TB_TIMEOUT = 16;
`else
    localparam int TB_TIMEOUT = 1024;
`endif

    logic         clk;
    logic         reset_n;
    logic [3:0]   req_val;
    logic [3:0]   req_rdy;
    logic [127:0] req_msg;
    logic [3:0]   resp_val;
    logic [3:0]   resp_rdy;
    logic [15:0]  resp_msg;
    logic         gcd_req_val;
    logic         gcd_req_rdy;
    logic [31:0]  gcd_req_msg;
    logic         gcd_resp_val;
    logic         gcd_resp_rdy;
    logic [15:0]  gcd_resp_msg;
    logic [1:0]   grant_id;
    logic         busy;
    logic         timeout;

    int n_tests = 0;
    int n_fail  = 0;

    gcd_arbiter #(.NREQ(4), .TIMEOUT(TB_TIMEOUT)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_val(req_val), .req_rdy(req_rdy), .req_msg(req_msg),
        .resp_val(resp_val), .resp_rdy(resp_rdy), .resp_msg(resp_msg),
        .gcd_req_val(gcd_req_val), .gcd_req_rdy(gcd_req_rdy), .gcd_req_msg(gcd_req_msg),
        .gcd_resp_val(gcd_resp_val), .gcd_resp_rdy(gcd_resp_rdy), .gcd_resp_msg(gcd_resp_msg),
        .grant_id(grant_id), .busy(busy), .timeout(timeout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL global_time_limit: got still running, expected finished");
        $fatal(1, "time limit");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset_n = 1'b0; req_val = '0; req_msg = '0; resp_rdy = '0;
        gcd_req_rdy = 1'b0; gcd_resp_val = 1'b0; gcd_resp_msg = '0;
        tick; tick;
        n_tests++; if ({busy, timeout, gcd_req_val} !== 3'b000) begin n_fail++;
            $display("FAIL reset_flags: got busy/timeout/gcd_req_val %b expected 000", {busy, timeout, gcd_req_val}); end
        n_tests++; if ({req_rdy, resp_val} !== 8'h00) begin n_fail++;
            $display("FAIL reset_rdy_val: got %h expected 00", {req_rdy, resp_val}); end
        n_tests++; if ({gcd_req_msg, resp_msg, grant_id} !== 50'd0) begin n_fail++;
            $display("FAIL reset_data: got %h expected 0", {gcd_req_msg, resp_msg, grant_id}); end
        n_tests++; if (gcd_resp_rdy !== 1'b1) begin n_fail++;
            $display("FAIL reset_drain: got gcd_resp_rdy %b expected 1", gcd_resp_rdy); end
        reset_n = 1'b1;
    endtask

    task automatic test_single;
        req_msg[31:0] = {16'd48, 16'd18};
        req_val = 4'b0001;
        #1;
        n_tests++; if (req_rdy !== 4'b0001) begin n_fail++;
            $display("FAIL single_req_rdy: got %b expected 0001", req_rdy); end
        tick;
        req_val = '0;
        n_tests++; if ({gcd_req_val, busy, grant_id} !== 4'b1100) begin n_fail++;
            $display("FAIL single_issue: got val/busy/id %b expected 1100", {gcd_req_val, busy, grant_id}); end
        n_tests++; if (gcd_req_msg !== {16'd48, 16'd18}) begin n_fail++;
            $display("FAIL single_issue_msg: got %h expected %h", gcd_req_msg, {16'd48, 16'd18}); end
        gcd_req_rdy = 1'b1;
        tick;
        gcd_req_rdy = 1'b0;
        n_tests++; if ({gcd_req_val, gcd_resp_rdy} !== 2'b01) begin n_fail++;
            $display("FAIL single_wait: got req_val/resp_rdy %b expected 01", {gcd_req_val, gcd_resp_rdy}); end
        gcd_resp_val = 1'b1; gcd_resp_msg = 16'd6;
        tick;
        gcd_resp_val = 1'b0; gcd_resp_msg = 16'd0;
        n_tests++; if (resp_val !== 4'b0001 || resp_msg !== 16'd6) begin n_fail++;
            $display("FAIL single_return: got resp_val %b msg %0d expected 0001 6", resp_val, resp_msg); end
        resp_rdy = 4'b0001;
        tick;
        resp_rdy = '0;
        n_tests++; if (resp_val !== 4'b0000 || busy !== 1'b0 || resp_msg !== 16'd6) begin n_fail++;
            $display("FAIL single_idle_hold: got resp_val %b busy %b msg %0d expected 0000 0 6", resp_val, busy, resp_msg); end
        req_val = 4'b1111;
        #1;
        n_tests++; if (req_rdy !== 4'b0010) begin n_fail++;
            $display("FAIL single_rr_ptr: got req_rdy %b expected 0010", req_rdy); end
        req_val = '0;
    endtask

    task automatic test_round_robin;
        logic [31:0] ops [4];
        logic [15:0] res [4];
        int exp_id [5];
        ops[0] = {16'd12, 16'd8};   res[0] = 16'd4;
        ops[1] = {16'd35, 16'd21};  res[1] = 16'd7;
        ops[2] = {16'd100, 16'd75}; res[2] = 16'd25;
        ops[3] = {16'd17, 16'd5};   res[3] = 16'd1;
        exp_id[0] = 0; exp_id[1] = 1; exp_id[2] = 2; exp_id[3] = 3; exp_id[4] = 0;
        reset_n = 1'b0;
        tick;
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) req_msg[32*i +: 32] = ops[i];
        req_val = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            int e;
            e = exp_id[n];
            #1;
            n_tests++; if (req_rdy !== 4'(1 << e)) begin n_fail++;
                $display("FAIL rr_winner[%0d]: got req_rdy %b expected %b", n, req_rdy, 4'(1 << e)); end
            tick;
            n_tests++; if (grant_id !== 2'(e) || gcd_req_msg !== ops[e]) begin n_fail++;
                $display("FAIL rr_issue[%0d]: got id %0d msg %h expected %0d %h", n, grant_id, gcd_req_msg, e, ops[e]); end
            gcd_req_rdy = 1'b1;
            tick;
            gcd_req_rdy = 1'b0;
            gcd_resp_val = 1'b1; gcd_resp_msg = res[e];
            tick;
            gcd_resp_val = 1'b0;
            n_tests++; if (resp_val !== 4'(1 << e) || resp_msg !== res[e]) begin n_fail++;
                $display("FAIL rr_return[%0d]: got %b %0d expected %b %0d", n, resp_val, resp_msg, 4'(1 << e), res[e]); end
            resp_rdy = 4'(1 << e);
            tick;
            resp_rdy = '0;
        end
        req_val = '0;
    endtask

    task automatic test_backpressure;
        // rr_ptr is 1 after the round-robin sequence; only requester 2 asks.
        req_msg[95:64] = {16'd84, 16'd36};
        req_val = 4'b0100;
        #1;
        n_tests++; if (req_rdy !== 4'b0100) begin n_fail++;
            $display("FAIL bp_winner: got %b expected 0100", req_rdy); end
        tick;
        req_val = '0;
        for (int c = 0; c < 5; c++) begin
            n_tests++; if (gcd_req_val !== 1'b1 || gcd_req_msg !== {16'd84, 16'd36} || grant_id !== 2'd2) begin n_fail++;
                $display("FAIL bp_issue_hold[%0d]: got val %b msg %h id %0d expected 1 %h 2", c, gcd_req_val, gcd_req_msg, grant_id, {16'd84, 16'd36}); end
            tick;
        end
        gcd_req_rdy = 1'b1;
        tick;
        gcd_req_rdy = 1'b0;
        gcd_resp_val = 1'b1; gcd_resp_msg = 16'd12;
        tick;
        gcd_resp_val = 1'b0; gcd_resp_msg = 16'd0;
        for (int c = 0; c < 3; c++) begin
            n_tests++; if (resp_val !== 4'b0100 || resp_msg !== 16'd12 || timeout !== 1'b0) begin n_fail++;
                $display("FAIL bp_return_hold[%0d]: got %b %0d to %b expected 0100 12 0", c, resp_val, resp_msg, timeout); end
            tick;
        end
        resp_rdy = 4'b0100;
        tick;
        resp_rdy = '0;
        n_tests++; if (resp_val !== 4'b0000 || busy !== 1'b0) begin n_fail++;
            $display("FAIL bp_release: got resp_val %b busy %b expected 0000 0", resp_val, busy); end
    endtask

    task automatic test_reset_mid_wait;
        // rr_ptr is 3; requester 0 wins after wrapping.
        req_msg[31:0] = {16'd9, 16'd6};
        req_val = 4'b0001;
        tick;
        req_val = '0;
        gcd_req_rdy = 1'b1;
        tick;
        gcd_req_rdy = 1'b0;
        n_tests++; if (busy !== 1'b1 || grant_id !== 2'd0 || gcd_resp_rdy !== 1'b1) begin n_fail++;
            $display("FAIL rst_pre_wait: got busy %b id %0d rdy %b expected 1 0 1", busy, grant_id, gcd_resp_rdy); end
        reset_n = 1'b0;
        #1;
        n_tests++; if ({busy, timeout, gcd_req_val, req_rdy, resp_val} !== 11'd0) begin n_fail++;
            $display("FAIL rst_async_ctrl: got %b expected 0", {busy, timeout, gcd_req_val, req_rdy, resp_val}); end
        n_tests++; if ({gcd_req_msg, resp_msg, grant_id} !== 50'd0 || gcd_resp_rdy !== 1'b1) begin n_fail++;
            $display("FAIL rst_async_data: got %h drain %b expected 0 1", {gcd_req_msg, resp_msg, grant_id}, gcd_resp_rdy); end
        tick;
        reset_n = 1'b1;
        gcd_resp_val = 1'b1; gcd_resp_msg = 16'd99;
        #1;
        n_tests++; if (gcd_resp_rdy !== 1'b1) begin n_fail++;
            $display("FAIL rst_stale_rdy: got %b expected 1", gcd_resp_rdy); end
        tick;
        gcd_resp_val = 1'b0; gcd_resp_msg = 16'd0;
        n_tests++; if (resp_val !== 4'b0000 || busy !== 1'b0 || resp_msg !== 16'd0) begin n_fail++;
            $display("FAIL rst_stale_drop: got %b %b %0d expected 0000 0 0", resp_val, busy, resp_msg); end
        req_val = 4'b1111;
        #1;
        n_tests++; if (req_rdy !== 4'b0001) begin n_fail++;
            $display("FAIL rst_rr_ptr: got %b expected 0001", req_rdy); end
        req_val = '0;
    endtask

`ifdef GCD_ARB_TIMEOUT_EN
    task automatic test_timeout;
        int  waited;
        bit  seen;
        req_msg[63:32] = {16'd30, 16'd20};
        req_val = 4'b0010;
        tick;
        req_val = '0;
        gcd_req_rdy = 1'b1;
        tick;
        gcd_req_rdy = 1'b0;
        seen = 1'b0;
        waited = 0;
        while (!seen && waited < 40) begin
            if (timeout === 1'b1) seen = 1'b1;
            else begin tick; waited++; end
        end
        n_tests++; if (!seen) begin n_fail++;
            $display("FAIL to_pulse: got no timeout in %0d cycles expected pulse", waited); end
        n_tests++; if (resp_val !== 4'b0010 || resp_msg !== 16'hFFFF) begin n_fail++;
            $display("FAIL to_return: got %b %h expected 0010 ffff", resp_val, resp_msg); end
        tick;
        n_tests++; if (timeout !== 1'b0 || resp_val !== 4'b0010) begin n_fail++;
            $display("FAIL to_one_cycle: got to %b resp_val %b expected 0 0010", timeout, resp_val); end
        resp_rdy = 4'b0010;
        tick;
        resp_rdy = '0;
        req_val = 4'b1111;
        #1;
        n_tests++; if (req_rdy !== 4'b0100 || busy !== 1'b0) begin n_fail++;
            $display("FAIL to_continue: got %b busy %b expected 0100 0", req_rdy, busy); end
        req_val = '0;
    endtask
`else
    task automatic test_no_timeout;
        req_msg[63:32] = {16'd30, 16'd20};
        req_val = 4'b0010;
        tick;
        req_val = '0;
        gcd_req_rdy = 1'b1;
        tick;
        gcd_req_rdy = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (timeout !== 1'b0 || resp_val !== 4'b0000 || busy !== 1'b1) begin
                n_tests++; n_fail++;
                $display("FAIL nto_stall[%0d]: got to %b resp_val %b busy %b expected 0 0000 1", c, timeout, resp_val, busy);
            end
            tick;
        end
        n_tests++;
        gcd_resp_val = 1'b1; gcd_resp_msg = 16'd10;
        tick;
        gcd_resp_val = 1'b0;
        if (resp_val !== 4'b0010 || resp_msg !== 16'd10) begin n_fail++;
            $display("FAIL nto_complete: got %b %0d expected 0010 10", resp_val, resp_msg); end
        resp_rdy = 4'b0010;
        tick;
        resp_rdy = '0;
    endtask
`endif

    initial begin
        test_reset;
        test_single;
        test_round_robin;
        test_backpressure;
        test_reset_mid_wait;
`ifdef GCD_ARB_TIMEOUT_EN
        test_timeout;
`else
        test_no_timeout;
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/gcd_arbiter.md
GCD_ARBITER -- requirements
Module: gcd_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 4: number of requesters sharing one gcd unit (fixed at 4 in this revision).
REQ-002 SHALL have parameter TIMEOUT, default 1024: watchdog limit in cycles, used only under GCD_ARB_TIMEOUT_EN.
REQ-003 SHALL have port clk  input  1: single clock; all state on its rising edge.
REQ-004 SHALL have port reset_n  input  1: asynchronous active-low reset.
REQ-005 SHALL have port req_val  input  4: per-requester request valid.
REQ-006 SHALL have port req_rdy  output  4: per-requester request ready.
REQ-007 SHALL have port req_msg  input  128: packed operands; requester i is bits [32i+31:32i], holding {a[15:0], b[15:0]}.
REQ-008 SHALL have port resp_val  output  4: per-requester response valid.
REQ-009 SHALL have port resp_rdy  input  4: per-requester response ready.
REQ-010 SHALL have port resp_msg  output  16: shared response data, meaningful only where resp_val is set.
REQ-011 SHALL have port gcd_req_val / gcd_req_rdy / gcd_req_msg  output / input / output  1 / 1 / 32: request side to gcd.
REQ-012 SHALL have port gcd_resp_val / gcd_resp_rdy / gcd_resp_msg  input / output / input  1 / 1 / 16: response side from gcd.
REQ-013 SHALL have port grant_id  output  2: index of the requester being served.
REQ-014 SHALL have port busy  output  1: high when state is not IDLE.
REQ-015 SHALL have port timeout  output  1: one-cycle pulse when the watchdog fires.

Function
REQ-016 SHALL implement an FSM with states IDLE, ISSUE, WAIT and RETURN, with at most one gcd transaction outstanding.
REQ-017 In IDLE, the winner SHALL be the first requester with req_val=1, scanning from rr_ptr upward modulo 4.
REQ-018 req_rdy SHALL be high only for the winner, only in IDLE, and combinational from req_val and rr_ptr.
REQ-019 On a req handshake, the FSM SHALL latch req_msg and grant_id and go to ISSUE.
REQ-020 In ISSUE, gcd_req_val=1 and gcd_req_msg=latched operands; on gcd_req_rdy=1 the FSM SHALL go to WAIT.
REQ-021 gcd_resp_rdy SHALL be 1 in WAIT and IDLE; responses in IDLE are stale and SHALL be discarded.
REQ-022 In WAIT, on gcd_resp_val=1 the FSM SHALL latch gcd_resp_msg and go to RETURN.
REQ-023 In RETURN, resp_val[grant_id]=1 and resp_msg=latched result; every other resp_val bit SHALL be 0.
REQ-024 On resp_rdy[grant_id]=1 in RETURN, rr_ptr SHALL become grant_id+1 (2-bit wrap, 3->0) and the FSM SHALL go to IDLE.
REQ-025 Latency SHALL be: req handshake to gcd_req_val = 1 cycle; gcd_resp handshake to resp_val = 1 cycle.
REQ-026 A requester deasserting req_val after losing SHALL NOT affect the current grant; ties SHALL be resolved by rr_ptr alone.
REQ-027 Outside their active states, all output valids and readies SHALL be 0 and resp_msg SHALL hold its last value.

Reset
REQ-028 Asserting reset_n=0 at any time, including mid-transaction, SHALL immediately force: state=IDLE, rr_ptr=0, grant_id=0, busy=0, timeout=0, req_rdy=0, resp_val=0, gcd_req_val=0, gcd_req_msg=0, resp_msg=0, watchdog=0.
REQ-029 After reset, gcd_resp_rdy SHALL be 1 (IDLE drain).
REQ-030 Reset deassertion is synchronized externally; the block SHALL be functional on the first edge after release.

Configuration
REQ-031 Macro GCD_ARB_TIMEOUT_EN defined: a cycle counter SHALL run in ISSUE and WAIT and clear on entry to ISSUE.
REQ-032 When that counter reaches TIMEOUT-1 without completing, the FSM SHALL go to RETURN with resp_msg=16'hFFFF and pulse timeout for one cycle.
REQ-033 Macro GCD_ARB_TIMEOUT_EN undefined: no counter SHALL exist, timeout SHALL be tied 0, and ISSUE/WAIT SHALL wait indefinitely.

Verification
REQ-034 Single request: req_val[0], msg {16'd48,16'd18}, gcd returns 6 -> resp_val[0]=1, resp_msg=6, rr_ptr=1.
REQ-035 All four requesters held valid from reset -> grants in order 0,1,2,3,0; no requester served twice before the others.
REQ-036 Backpressure: gcd_req_rdy low 5 cycles, then resp_rdy[2] low 3 cycles -> gcd_req_val and resp_val[2] stable, data unchanged.
REQ-037 Reset mid-WAIT (reset_n=0 for 1 cycle) -> all outputs at reset values; a late gcd response in IDLE is dropped, no resp_val.
REQ-038 With GCD_ARB_TIMEOUT_EN and TIMEOUT=16, gcd never responds -> timeout pulse, resp_msg=16'hFFFF to the granted requester, arbitration continues.
